divider_iter: RTL and testbench
===============================

# divider_iter

Iterative unsigned radix-2 restoring divider that serves as the responder side of the execute-stage `valid`/`done` multi-cycle handshake. The execute-stage issuer drives operands and holds `valid`; this block computes one quotient bit per cycle and pulses `done` with `{remainder, quotient}` on `c`. The issuer handles sign correction and divide-by-zero shortcuts, but this block must still produce a defined result for `b == 0`. It is parameterised so one RTL source serves both the 32-bit (word) and 64-bit divide paths.

## Interface
- `WIDTH`, default 64: operand width; legal values are 32 and 64.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low; 0 = reset, sampled on `clk` rising edge.
- `valid`  in  1  request. The issuer holds it high with stable `a`/`b` until it samples `done`.
- `a`  in  WIDTH  dividend, unsigned.
- `b`  in  WIDTH  divisor, unsigned.
- `done`  out  1  result valid; a one-cycle pulse.
- `c`  out  2*WIDTH  result: `c[2*WIDTH-1:WIDTH]` = remainder, `c[WIDTH-1:0]` = quotient.

## Operation
- FSM states:
  - IDLE: if `valid`=1, latch `a` into the quotient/shift register, latch `b` into the divisor register, clear the partial remainder (WIDTH+1 bits) and the count (clog2(WIDTH)+1 bits), then go to BUSY.
  - BUSY: each cycle, shift `{rem, q}` left by 1 and form `trial = rem_shifted - {1'b0, divisor}`.
    - If `trial` is non-negative: `rem <= trial`, shifted-in quotient bit = 1.
    - Otherwise: keep the shifted remainder, shifted-in quotient bit = 0.
    - Increment count. After the WIDTH-th step, go to DONE.
  - DONE: `done`=1 and `c` = final `{rem[WIDTH-1:0], q}`. Unconditionally return to IDLE on the next edge.
- Abort: `valid`=0 while in BUSY returns to IDLE next edge (pipeline flush); no `done` is produced.
- Operands are sampled only in IDLE. Changes to `a`/`b` during BUSY are ignored.
- `b` = 0 falls out of the algorithm naturally: quotient = all ones, remainder = `a`. This matches RISC-V DIVU/REMU.
- Back-to-back: if `valid` is still high in IDLE right after DONE, it is treated as a new request with the current `a`/`b`.
- `c` is registered and holds its last value outside DONE. Only the DONE cycle is meaningful.

## Timing
- Reset (`reset`=0 at an edge): state = IDLE, count = 0, `done` = 0, `c` = 0. This applies from any state, including mid-BUSY; no `done` follows.
- Cycle numbering: cycle 0 is the edge where `valid` is first sampled high in IDLE.
  - BUSY occupies cycles 1..WIDTH.
  - `done`=1 during cycle WIDTH+1.
  - Latency is WIDTH+1 cycles: 65 for WIDTH=64, 33 for WIDTH=32.
- `done` is a Moore output (state == DONE) with no combinational path from `valid`.
- Throughput: one result per WIDTH+2 cycles when `valid` is held continuously.
- `valid` dropping during the DONE cycle has no effect. The result is already presented and the FSM returns to IDLE.
- Reset is synchronous: asynchronous assertion does not change state until the next `clk` edge.

## Structure
- Use the existing `common` package types `u32`, `u64`, `u128` for ports when instantiated at fixed widths. Declare the FSM state enum (IDLE/BUSY/DONE) locally in the module, not in a package.
- Add nothing to `pipes`.
- One sub-module is natural: `div_step`, a combinational single restoring step. Inputs: `{rem, q}`, divisor. Outputs: next `{rem, q}`. It allows later unrolling to 2 bits/cycle.
- Estimated RTL size: about 150 lines.

## Test plan
- WIDTH=64, `a`=100, `b`=7, `valid` held: `done` only at cycle 65, `c` = {64'd2, 64'd14}; `done` low in cycles 1–64 and 66.
- WIDTH=64, `a`=64'hFFFF_FFFF_FFFF_FFFF, `b`=1: quotient = all ones, remainder = 0. Then `b`=0, `a`=5: quotient = 64'hFFFF_FFFF_FFFF_FFFF, remainder = 5.
- WIDTH=32, `a`=32'h8000_0000, `b`=3: at cycle 33, quotient = 32'h2AAA_AAAA, remainder = 2.
- Abort: start `a`=1000, `b`=10, drop `valid` at cycle 20. No `done` appears. Reassert `valid` with `a`=9, `b`=4: `done` arrives 65 cycles later with quotient 2, remainder 1.
- Back-to-back: keep `valid` high, change `a`/`b` to 50/5 in the DONE cycle. The second `done` occurs 66 cycles after the first with quotient 10, remainder 0; the change to `a`/`b` during BUSY of the first op does not alter the first result.
- Reset mid-op: `reset`=0 for one edge at cycle 30. Next cycle `done`=0 and `c`=0, state is IDLE; with `valid` still high a fresh 65-cycle operation follows.

Source files
------------

// File: rtl/divider_iter_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
// Fixed-width aliases are for instantiating the divider on the word/doubleword paths.
package divider_iter_pkg;

  typedef logic [31:0]  u32;
  typedef logic [63:0]  u64;
  typedef logic [127:0] u128;

  localparam int DIV_WIDTH_DEFAULT = 64;

  // One extra bit so the count can reach WIDTH without wrapping.
  function automatic int count_bits(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/divider_iter_div_step.sv
// One combinational radix-2 restoring step on {rem, quo}.
// Kept separate so two of these can later be chained for 2 bits per cycle.
module div_step
  import divider_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             take;

  // The full-width compare decides the quotient bit; the narrower subtract is exact whenever it is taken.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    take    = (shifted >= {2'b00, divisor_i});
    diff    = shifted[WIDTH:0] - {1'b0, divisor_i};
    rem_o   = take ? diff : shifted[WIDTH:0];
    quo_o   = {quo_i[WIDTH-2:0], take};
  end

endmodule

// File: rtl/divider_iter.sv
// Iterative unsigned divider: one quotient bit per cycle, done pulses with {remainder, quotient}.
// Responder side of the execute-stage valid/done handshake; valid low mid-operation flushes it.
module divider_iter
  import divider_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);

  localparam int CW = count_bits(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [2*WIDTH-1:0] c_q, c_d;

  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          quo_d   = a;
          div_d   = b;
          rem_d   = '0;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!valid) begin
          state_d = IDLE;
        end else begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + CW'(1);
          // The result register is loaded on the final step so c is stable for the whole DONE cycle.
          if (count_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            c_d     = {step_rem[WIDTH-1:0], step_quo};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      c_q     <= c_d;
    end
  end

  assign done = (state_q == DONE);
  assign c    = c_q;

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter: a 64-bit and a 32-bit instance share clock and reset.
// A transaction-level model predicts done/c every cycle; directed cases pin known answers.
module tb_divider_iter;

  logic         clk;
  logic         reset;
  logic         valid0, valid1;
  logic [63:0]  a0, b0;
  logic [31:0]  a1, b1;
  logic         done0, done1;
  logic [127:0] c0;
  logic [63:0]  c1;

  int tests    = 0;
  int failures = 0;
  bit check_en = 0;

  // Model state per lane (0 = 64-bit, 1 = 32-bit)
  bit           m_busy [2];
  bit           m_done [2];
  int           m_left [2];
  logic [127:0] m_exp  [2];
  logic [127:0] m_c    [2];

  divider_iter #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .valid(valid0), .a(a0), .b(b0), .done(done0), .c(c0)
  );

  divider_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .valid(valid1), .a(a1), .b(b1), .done(done1), .c(c1)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Arithmetic definition of the answer, including the divide-by-zero convention
  function automatic logic [127:0] refResult(input int w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, av, bv, q, r;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    av = a & mask;
    bv = b & mask;
    if (bv == 64'd0) begin
      q = mask;
      r = av;
    end else begin
      q = av / bv;
      r = av % bv;
    end
    if (w == 64) return {r, q};
    return {64'd0, r[31:0], q[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic validOf(input int lane);
    return (lane == 0) ? valid0 : valid1;
  endfunction

  function automatic logic doneOf(input int lane);
    return (lane == 0) ? done0 : done1;
  endfunction

  function automatic logic [127:0] cOf(input int lane);
    return (lane == 0) ? c0 : {64'd0, c1};
  endfunction

  task automatic applyStimulus(input int lane, input logic v, input logic [63:0] av, input logic [63:0] bv);
    if (lane == 0) begin
      valid0 = v;
      a0     = av;
      b0     = bv;
    end else begin
      valid1 = v;
      a1     = av[31:0];
      b1     = bv[31:0];
    end
  endtask

  // Count negedges until done, bounded; a missing done is reported as a failure.
  task automatic waitDone(input int lane, input int maxc, output int lat, output logic [127:0] res);
    bit seen;
    seen = 0;
    lat  = 0;
    res  = '0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      lat++;
      if (doneOf(lane)) begin
        res  = cOf(lane);
        seen = 1;
        break;
      end
    end
    #1;
    checkOutput("done_within_bound", {127'd0, seen}, 128'd1);
  endtask

  task automatic runOp(input int lane, input logic [63:0] av, input logic [63:0] bv,
                       output int lat, output logic [127:0] res);
    applyStimulus(lane, 1'b1, av, bv);
    waitDone(lane, 200, lat, res);
  endtask

  function automatic logic [63:0] randOperand(input bit allow_zero);
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = allow_zero ? 64'd0 : 64'd1;
      1, 2:    v = 64'($urandom_range(1, 20));
      3:       v = {32'd0, $urandom};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Transaction model: a request captured in idle yields done exactly WIDTH+1 edges later unless flushed or reset
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int          w;
      logic        v;
      logic [63:0] av, bv;
      w  = (i == 0) ? 64 : 32;
      v  = (i == 0) ? valid0 : valid1;
      av = (i == 0) ? a0 : {32'd0, a1};
      bv = (i == 0) ? b0 : {32'd0, b1};
      if (!reset) begin
        m_busy[i] = 0;
        m_done[i] = 0;
        m_c[i]    = '0;
      end else if (m_done[i]) begin
        m_done[i] = 0;
      end else if (!m_busy[i]) begin
        if (v) begin
          m_busy[i] = 1;
          m_left[i] = w;
          m_exp[i]  = refResult(w, av, bv);
        end
      end else if (!v) begin
        m_busy[i] = 0;
      end else begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_busy[i] = 0;
          m_done[i] = 1;
          m_c[i]    = m_exp[i];
        end
      end
    end
  end

  // Compare both lanes against the model on every cycle once reset has been applied
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("done64", {127'd0, done0}, {127'd0, m_done[0]});
      checkOutput("c64", c0, m_c[0]);
      checkOutput("done32", {127'd0, done1}, {127'd0, m_done[1]});
      checkOutput("c32", {64'd0, c1}, m_c[1]);
    end
  end

  initial begin
    int           lat;
    int           pulses;
    logic [127:0] res;

    reset = 0;
    applyStimulus(0, 1'b0, 64'd0, 64'd0);
    applyStimulus(1, 1'b0, 64'd0, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_en = 1;
    checkOutput("reset_done", {127'd0, done0}, 128'd0);
    checkOutput("reset_c", c0, 128'd0);
    @(negedge clk);
    #1 reset = 1;

    checkOutput("ref_100_7", refResult(64, 64'd100, 64'd7), {64'd2, 64'd14});
    checkOutput("ref_div0", refResult(32, 64'd5, 64'd0), {64'd0, 32'd5, 32'hFFFF_FFFF});

    runOp(0, 64'd100, 64'd7, lat, res);
    checkOutput("lat_100_7", lat, 128'd65);
    checkOutput("c_100_7", res, {64'd2, 64'd14});
    applyStimulus(0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    checkOutput("done_cycle66", {127'd0, done0}, 128'd0);
    #1;

    runOp(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat, res);
    checkOutput("c_ones_div1", res, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    applyStimulus(0, 1'b0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    #1;
    runOp(0, 64'd5, 64'd0, lat, res);
    checkOutput("c_div_by_zero", res, {64'd5, 64'hFFFF_FFFF_FFFF_FFFF});
    applyStimulus(0, 1'b0, 64'd0, 64'd0);

    runOp(1, 64'h8000_0000, 64'd3, lat, res);
    checkOutput("lat32", lat, 128'd33);
    checkOutput("c32_8000_0000_3", res, {64'd0, 32'd2, 32'h2AAA_AAAA});
    applyStimulus(1, 1'b0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    #1;

    // Flush mid-operation: no done may follow
    applyStimulus(0, 1'b1, 64'd1000, 64'd10);
    repeat (20) @(negedge clk);
    #1 applyStimulus(0, 1'b0, 64'd1000, 64'd10);
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      if (done0) pulses++;
    end
    #1;
    checkOutput("abort_no_done", pulses, 128'd0);
    runOp(0, 64'd9, 64'd4, lat, res);
    checkOutput("lat_after_abort", lat, 128'd65);
    checkOutput("c_9_4", res, {64'd1, 64'd2});
    applyStimulus(0, 1'b0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    #1;

    // Back-to-back with operand noise during BUSY of the first request
    applyStimulus(0, 1'b1, 64'd1000, 64'd7);
    repeat (10) @(negedge clk);
    #1 applyStimulus(0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    waitDone(0, 200, lat, res);
    checkOutput("lat_b2b_first", lat + 10, 128'd65);
    checkOutput("c_1000_7", res, {64'd6, 64'd142});
    applyStimulus(0, 1'b1, 64'd50, 64'd5);
    waitDone(0, 200, lat, res);
    checkOutput("lat_b2b_second", lat, 128'd66);
    checkOutput("c_50_5", res, {64'd0, 64'd10});

    // Reset mid-operation with valid held
    applyStimulus(0, 1'b1, 64'd12345, 64'd67);
    repeat (30) @(negedge clk);
    #1 reset = 0;
    @(negedge clk);
    checkOutput("midreset_done", {127'd0, done0}, 128'd0);
    checkOutput("midreset_c", c0, 128'd0);
    #1 reset = 1;
    waitDone(0, 200, lat, res);
    checkOutput("lat_after_reset", lat, 128'd65);
    checkOutput("c_12345_67", res, {64'd17, 64'd184});
    applyStimulus(0, 1'b0, 64'd0, 64'd0);

    // Randomised traffic on both lanes, judged by the model
    repeat (4000) begin
      @(negedge clk);
      #1;
      reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      for (int lane = 0; lane < 2; lane++) begin
        logic        v;
        logic [63:0] av, bv;
        v  = validOf(lane);
        av = (lane == 0) ? a0 : {32'd0, a1};
        bv = (lane == 0) ? b0 : {32'd0, b1};
        if (v) v = ($urandom_range(0, 149) != 0);
        else   v = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 3) == 0) begin
          av = randOperand(1'b1);
          bv = randOperand(1'b1);
        end
        applyStimulus(lane, v, av, bv);
      end
    end
    reset = 1;
    applyStimulus(0, 1'b0, 64'd0, 64'd0);
    applyStimulus(1, 1'b0, 64'd0, 64'd0);
    repeat (80) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
